alu_serial_rx: RTL and testbench



---
 rtl/alu_serial_rx_if.sv | 13 +
 rtl/alu_serial_rx.sv | 157 +++++++++++++++
 tb/tb_alu_serial_rx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_rx_if.sv
// Command output bus of the ALU serial receiver: one decoded command per
// valid/ready transfer.
interface alu_serial_rx_if #(parameter int DATA_W = 32);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [2:0]        cmd_op;
  logic [3:0]        cmd_err;

  modport master (output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_err, input cmd_ready);
  modport slave  (input cmd_valid, cmd_a, cmd_b, cmd_op, cmd_err, output cmd_ready);
endinterface

// File: rtl/alu_serial_rx.sv
// Receive front-end for the ALU serial command protocol: deserializes 11-bit
// frames, assembles A/B/op, checks CRC-4, count, framing and opcode legality.
module alu_serial_rx #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sin,
  alu_serial_rx_if.master cmd,
  output logic            busy,
  output logic [7:0]      drop_cnt
);
  localparam int N_BYTES = DATA_W / 8;
  localparam int N_FR    = 2 * N_BYTES;
  localparam int CW      = $clog2(N_FR + 1);
  localparam int GW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {HUNT, RECV, GAP, DONE, WAIT_HIGH} state_t;

  state_t              state;
  logic [3:0]          bit_cnt;
  logic                is_ctl;
  logic [7:0]          sh;
  logic [CW-1:0]       frm_cnt;
  logic [2*DATA_W-1:0] ab;
  logic [3:0]          crc, rx_crc;
  logic [2:0]          rx_op;
  logic                data_err, frame_err;
  logic [GW-1:0]       gap_cnt;

  logic              valid_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0]        op_q;
  logic [3:0]        err_q;

  logic [3:0] err_res;
  logic       op_ok;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
  endfunction

  // Error priority: framing aborts everything; crc only counts with a clean
  // data count; op legality only counts with clean data and crc.
  always_comb begin
    op_ok = (rx_op == 3'b000) || (rx_op == 3'b001) || (rx_op == 3'b100) || (rx_op == 3'b101);
    err_res = 4'b0000;
    if (frame_err)          err_res = 4'b1000;
    else if (data_err)      err_res = 4'b0100;
    else if (rx_crc != crc) err_res = 4'b0010;
    else if (!op_ok)        err_res = 4'b0001;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      bit_cnt   <= '0;
      is_ctl    <= 1'b0;
      sh        <= '0;
      frm_cnt   <= '0;
      ab        <= '0;
      crc       <= '0;
      rx_crc    <= '0;
      rx_op     <= '0;
      data_err  <= 1'b0;
      frame_err <= 1'b0;
      gap_cnt   <= '0;
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      err_q     <= '0;
      busy      <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (valid_q && cmd.cmd_ready) valid_q <= 1'b0;
      case (state)
        HUNT: if (!sin) begin
          state     <= RECV;
          bit_cnt   <= 4'd1;
          busy      <= 1'b1;
          frm_cnt   <= '0;
          ab        <= '0;
          crc       <= '0;
          data_err  <= 1'b0;
          frame_err <= 1'b0;
        end
        GAP: begin
          if (!sin) begin
            state   <= RECV;
            bit_cnt <= 4'd1;
          end else if (TIMEOUT_CYC != 0 && gap_cnt == GW'(TIMEOUT_CYC)) begin
            data_err <= 1'b1;
            state    <= DONE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        RECV: begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd1) begin
            is_ctl <= sin;
            // the constant '1' between B and op in the CRC stream
            if (sin) crc <= crc_step(crc, 1'b1);
          end else if (bit_cnt <= 4'd9) begin
            sh <= {sh[6:0], sin};
            if (is_ctl ? (bit_cnt >= 4'd3 && bit_cnt <= 4'd5) : (frm_cnt != CW'(N_FR)))
              crc <= crc_step(crc, sin);
          end else begin
            gap_cnt <= '0;
            if (!sin) begin
              frame_err <= 1'b1;
              state     <= DONE;
            end else if (is_ctl) begin
              rx_op  <= sh[6:4];
              rx_crc <= sh[3:0];
              if (frm_cnt != CW'(N_FR)) data_err <= 1'b1;
              state  <= DONE;
            end else begin
              if (frm_cnt == CW'(N_FR)) data_err <= 1'b1;
              else begin
                for (int i = 0; i < N_FR; i++)
                  if (frm_cnt == CW'(i)) ab[(N_FR-1-i)*8 +: 8] <= sh;
                frm_cnt <= frm_cnt + 1'b1;
              end
              state <= GAP;
            end
          end
        end
        DONE: begin
          state <= frame_err ? WAIT_HIGH : HUNT;
          busy  <= 1'b0;
          if (valid_q && !cmd.cmd_ready) begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end else begin
            valid_q <= 1'b1;
            err_q   <= err_res;
            a_q     <= frame_err ? '0 : ab[2*DATA_W-1 -: DATA_W];
            b_q     <= frame_err ? '0 : ab[DATA_W-1:0];
            op_q    <= (err_res == 4'b0000) ? rx_op : 3'b000;
          end
        end
        WAIT_HIGH: if (sin) state <= HUNT;
        default: state <= HUNT;
      endcase
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_a     = a_q;
  assign cmd.cmd_b     = b_q;
  assign cmd.cmd_op    = op_q;
  assign cmd.cmd_err   = err_q;
endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed + randomized bench for alu_serial_rx (32-bit and 16-bit instances)
// against a polynomial-division CRC model and rule-based expected outcomes.
module tb_alu_serial_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin32 = 1'b1, sin16 = 1'b1;
  logic       busy32, busy16;
  logic [7:0] drop32, drop16;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  alu_serial_rx_if #(.DATA_W(32)) if32();
  alu_serial_rx_if #(.DATA_W(16)) if16();

  alu_serial_rx #(.DATA_W(32), .TIMEOUT_CYC(64)) u32 (
    .clk(clk), .rst_n(rst_n), .sin(sin32), .cmd(if32), .busy(busy32), .drop_cnt(drop32));
  alu_serial_rx #(.DATA_W(16), .TIMEOUT_CYC(64)) u16 (
    .clk(clk), .rst_n(rst_n), .sin(sin16), .cmd(if16), .busy(busy16), .drop_cnt(drop16));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] o_valid(int sel); return sel ? 64'(if16.cmd_valid) : 64'(if32.cmd_valid); endfunction
  function automatic logic [63:0] o_a(int sel);     return sel ? 64'(if16.cmd_a)     : 64'(if32.cmd_a);     endfunction
  function automatic logic [63:0] o_b(int sel);     return sel ? 64'(if16.cmd_b)     : 64'(if32.cmd_b);     endfunction
  function automatic logic [63:0] o_op(int sel);    return sel ? 64'(if16.cmd_op)    : 64'(if32.cmd_op);    endfunction
  function automatic logic [63:0] o_err(int sel);   return sel ? 64'(if16.cmd_err)   : 64'(if32.cmd_err);   endfunction

  // CRC as the remainder of (message * x^4) divided by x^4 + x + 1
  function automatic logic [3:0] crc_model(logic [63:0] a, logic [63:0] b, logic [2:0] op, int w);
    bit q[$];
    int n;
    for (int i = w-1; i >= 0; i--) q.push_back(a[i]);
    for (int i = w-1; i >= 0; i--) q.push_back(b[i]);
    q.push_back(1'b1);
    for (int i = 2; i >= 0; i--) q.push_back(op[i]);
    repeat (4) q.push_back(1'b0);
    n = q.size();
    for (int i = 0; i < n-4; i++)
      if (q[i]) begin q[i] ^= 1'b1; q[i+3] ^= 1'b1; q[i+4] ^= 1'b1; end
    return {q[n-4], q[n-3], q[n-2], q[n-1]};
  endfunction

  function automatic bit legal_op(logic [2:0] op);
    return op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5;
  endfunction

  task automatic send_bit(input int sel, input logic b);
    @(negedge clk);
    if (sel != 0) sin16 = b; else sin32 = b;
  endtask

  task automatic idle(input int sel, input int n);
    repeat (n) send_bit(sel, 1'b1);
  endtask

  task automatic send_frame(input int sel, input logic typ, input logic [7:0] pl, input logic stop);
    send_bit(sel, 1'b0);
    send_bit(sel, typ);
    for (int i = 7; i >= 0; i--) send_bit(sel, pl[i]);
    send_bit(sel, stop);
  endtask

  task automatic send_data(input int sel, input logic [63:0] a, input logic [63:0] b,
                           input int nfr, input int gap_at, input int gap_len);
    int nb;
    logic [7:0] bt;
    nb = (sel != 0) ? 2 : 4;
    for (int i = 0; i < nfr; i++) begin
      if (i < nb)        bt = a[(nb-1-i)*8 +: 8];
      else if (i < 2*nb) bt = b[(2*nb-1-i)*8 +: 8];
      else               bt = 8'($urandom);
      send_frame(sel, 1'b0, bt, 1'b1);
      if (i == gap_at) idle(sel, gap_len);
    end
  endtask

  // Call right after the final stop bit is driven: valid must rise exactly one
  // clock after the edge that samples it.
  task automatic expect_cmd(input int sel, input string tag, input logic [3:0] err,
                            input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                            input bit chk_ab);
    logic rdy;
    @(posedge clk); #1;
    chk({tag, ".early"}, o_valid(sel), 64'd0);
    @(posedge clk); #1;
    chk({tag, ".valid"}, o_valid(sel), 64'd1);
    chk({tag, ".err"}, o_err(sel), 64'(err));
    chk({tag, ".op"}, o_op(sel), 64'(op));
    if (chk_ab) begin
      chk({tag, ".a"}, o_a(sel), a);
      chk({tag, ".b"}, o_b(sel), b);
    end
    rdy = (sel != 0) ? if16.cmd_ready : if32.cmd_ready;
    if (rdy) begin
      @(posedge clk); #1;
      chk({tag, ".drop_valid"}, o_valid(sel), 64'd0);
    end
  endtask

  task automatic run_pkt(input int sel, input string tag, input logic [63:0] a_in,
                         input logic [63:0] b_in, input logic [2:0] op, input logic [3:0] crc,
                         input int nfr, input int gap_at, input int gap_len);
    int w;
    logic [63:0] a, b, mask;
    logic [3:0] e;
    w = (sel != 0) ? 16 : 32;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    if (nfr != w/4)                        e = 4'b0100;
    else if (crc != crc_model(a, b, op, w)) e = 4'b0010;
    else if (!legal_op(op))                e = 4'b0001;
    else                                   e = 4'b0000;
    send_data(sel, a, b, nfr, gap_at, gap_len);
    send_frame(sel, 1'b1, {1'b0, op, crc}, 1'b1);
    expect_cmd(sel, tag, e, a, b, (e == 4'b0000) ? op : 3'b000, e == 4'b0000);
  endtask

  initial begin
    logic [63:0] ra, rb, pa, pb;
    logic [2:0]  rop;
    logic [3:0]  rcrc;
    int k;
    bit seen;

    if32.cmd_ready = 1'b1;
    if16.cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.valid", o_valid(0), 64'd0);
    chk("rst.a", o_a(0), 64'd0);
    chk("rst.b", o_b(0), 64'd0);
    chk("rst.op", o_op(0), 64'd0);
    chk("rst.err", o_err(0), 64'd0);
    chk("rst.busy", 64'(busy32), 64'd0);
    chk("rst.drop", 64'(drop32), 64'd0);
    chk("rst.valid16", o_valid(1), 64'd0);
    rst_n = 1'b1;
    idle(0, 3);

    run_pkt(0, "add", 64'd1, 64'd2, 3'b100, 4'hA, 8, -1, 0);
    run_pkt(0, "badcrc", 64'd1, 64'd2, 3'b100, 4'hB, 8, -1, 0);
    run_pkt(0, "cnt7", 64'd1, 64'd2, 3'b100, 4'hA, 7, -1, 0);
    run_pkt(0, "cnt9", 64'd1, 64'd2, 3'b100, 4'hA, 9, -1, 0);
    ra = 64'h1234_5678; rb = 64'h9abc_def0;
    run_pkt(0, "illop", ra, rb, 3'b010, crc_model(ra, rb, 3'b010, 32), 8, -1, 0);

    // framing error in frame 3, then sin held low: no new start may be taken
    send_frame(0, 1'b0, 8'h11, 1'b1);
    send_frame(0, 1'b0, 8'h22, 1'b1);
    #1 chk("frm.busy_in_pkt", 64'(busy32), 64'd1);
    send_frame(0, 1'b0, 8'h33, 1'b0);
    expect_cmd(0, "frm", 4'b1000, 64'd0, 64'd0, 3'b000, 1'b1);
    repeat (15) @(negedge clk);
    #1;
    chk("frm.low_busy", 64'(busy32), 64'd0);
    chk("frm.low_valid", o_valid(0), 64'd0);
    idle(0, 2);
    ra = 64'hcafe_0001; rb = 64'h0000_beef;
    run_pkt(0, "frm.recover", ra, rb, 3'b101, crc_model(ra, rb, 3'b101, 32), 8, -1, 0);

    // timeout after 4 data frames: A kept, B zero-filled
    ra = 64'($urandom);
    send_data(0, ra, 64'd0, 4, -1, 0);
    seen = 1'b0;
    k = 0;
    for (int i = 1; i <= 90 && !seen; i++) begin
      send_bit(0, 1'b1);
      @(posedge clk); #1;
      if (o_valid(0) == 64'd1) begin seen = 1'b1; k = i; end
    end
    chk("tmo.seen", 64'(seen), 64'd1);
    chk("tmo.after_limit", 64'(k >= 65 && k <= 67), 64'd1);
    chk("tmo.err", o_err(0), 64'd4);
    chk("tmo.a", o_a(0), ra);
    chk("tmo.b", o_b(0), 64'd0);
    chk("tmo.op", o_op(0), 64'd0);
    idle(0, 3);

    // a gap of exactly the limit is still inside the packet
    ra = 64'($urandom); rb = 64'($urandom);
    run_pkt(0, "gap64", ra, rb, 3'b001, crc_model(ra, rb, 3'b001, 32), 8, 3, 64);

    for (int n = 0; n < 8; n++) begin
      ra = 64'($urandom); rb = 64'($urandom);
      rop = 3'($urandom_range(0, 7));
      rcrc = crc_model(ra, rb, rop, 32);
      if ($urandom_range(0, 3) == 0) rcrc ^= 4'(1 << $urandom_range(0, 3));
      run_pkt(0, $sformatf("rnd%0d", n), ra, rb, rop, rcrc, 8,
              int'($urandom_range(0, 7)), int'($urandom_range(0, 20)));
      idle(0, int'($urandom_range(0, 4)));
    end

    // output stall: second command dropped, first held
    if32.cmd_ready = 1'b0;
    pa = 64'($urandom); pb = 64'($urandom);
    run_pkt(0, "stall1", pa, pb, 3'b100, crc_model(pa, pb, 3'b100, 32), 8, -1, 0);
    ra = 64'($urandom); rb = 64'($urandom);
    send_data(0, ra, rb, 8, -1, 0);
    send_frame(0, 1'b1, {1'b0, 3'b000, crc_model(ra, rb, 3'b000, 32)}, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("stall.valid", o_valid(0), 64'd1);
    chk("stall.a_held", o_a(0), pa);
    chk("stall.b_held", o_b(0), pb);
    chk("stall.drop", 64'(drop32), 64'd1);
    if32.cmd_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall.release", o_valid(0), 64'd0);

    // asynchronous reset mid-frame
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("arst.busy", 64'(busy32), 64'd0);
    chk("arst.drop", 64'(drop32), 64'd0);
    chk("arst.a", o_a(0), 64'd0);
    sin32 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (o_valid(0) == 64'd1 || busy32) seen = 1'b1;
    end
    chk("arst.no_cmd", 64'(seen), 64'd0);
    ra = 64'($urandom); rb = 64'($urandom);
    run_pkt(0, "arst.after", ra, rb, 3'b101, crc_model(ra, rb, 3'b101, 32), 8, -1, 0);

    // 16-bit instance
    run_pkt(1, "w16.good", 64'h00a5, 64'h3c01, 3'b100, crc_model(64'h00a5, 64'h3c01, 3'b100, 16), 4, -1, 0);
    for (int n = 0; n < 3; n++) begin
      ra = 64'($urandom); rb = 64'($urandom);
      rop = 3'($urandom_range(0, 7));
      run_pkt(1, $sformatf("w16.rnd%0d", n), ra, rb, rop,
              crc_model(ra & 64'hffff, rb & 64'hffff, rop, 16), 4, -1, 0);
    end
    run_pkt(1, "w16.cnt5", 64'h1111, 64'h2222, 3'b000, 4'h0, 5, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
